// File: rtl/led_scan_controller.sv
// LED bounce scanner sequencer: prescaled tick, bounded one-hot walk with end dwell.
// Optional LED_SCAN_TRAIL_EN keeps the previous position lit as a trail LED.
module led_scan_controller #(
    parameter int NUM_LEDS = 10,
    parameter int POS_W    = 4,
    parameter int BASE_DIV = 3125000,
    parameter int DWELL    = 2
) (
    input  logic                CLOCK_50,
    input  logic                reset_n,
    input  logic                run,
    input  logic                step,
    input  logic [1:0]          speed_sel,
    input  logic [POS_W-1:0]    lo_bound,
    input  logic [POS_W-1:0]    hi_bound,
    output logic [NUM_LEDS-1:0] LEDR,
    output logic [POS_W-1:0]    pos,
    output logic                dir_up,
    output logic                at_end,
    output logic                busy
);

    localparam logic [POS_W-1:0] MAX_POS    = POS_W'(NUM_LEDS - 1);
    localparam logic [31:0]      BASE_W     = 32'(BASE_DIV);
    localparam int               DW_W       = (DWELL > 0) ? $clog2(DWELL + 1) : 1;
    localparam logic [DW_W-1:0]  DWELL_INIT = DW_W'(DWELL);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        UP,
        DWELL_HI,
        DOWN,
        DWELL_LO
    } state_t;

    function automatic logic [NUM_LEDS-1:0] onehot(input logic [POS_W-1:0] p);
        onehot = NUM_LEDS'(1) << p;
    endfunction

    state_t              state_q, state_d;
    logic [31:0]         presc_q, presc_d;
    logic [POS_W-1:0]    pos_q, pos_d;
    logic [POS_W-1:0]    lo_l_q, lo_l_d;
    logic [POS_W-1:0]    hi_l_q, hi_l_d;
    logic [DW_W-1:0]     dwell_q, dwell_d;
    logic                dir_up_q, dir_up_d;
    logic [NUM_LEDS-1:0] led_q, led_d;

    logic [31:0]      period;
    logic             tick;
    logic             adv;
    logic             bounds_bad;
    logic [POS_W-1:0] pos_inc;
    logic [POS_W-1:0] pos_dec;
    logic [DW_W-1:0]  dwell_dec;

    // Using >= rather than == lets a shortened period take effect without a full wrap.
    always_comb begin
        period  = BASE_W << {speed_sel, 1'b0};
        tick    = run && (presc_q >= period - 32'd1);
        presc_d = presc_q;
        if (run) begin
            presc_d = tick ? 32'd0 : presc_q + 32'd1;
        end
        adv = run ? tick : step;
    end

    assign bounds_bad = (lo_bound >= hi_bound) || (hi_bound > MAX_POS);
    assign pos_inc    = pos_q + POS_W'(1);
    assign pos_dec    = pos_q - POS_W'(1);
    assign dwell_dec  = dwell_q - DW_W'(1);

    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        dir_up_d = dir_up_q;
        dwell_d  = dwell_q;
        lo_l_d   = lo_l_q;
        hi_l_d   = hi_l_q;
        case (state_q)
            IDLE: begin
                if (adv) begin
                    state_d = LOAD;
                    if (bounds_bad) begin
                        lo_l_d = '0;
                        hi_l_d = MAX_POS;
                    end else begin
                        lo_l_d = lo_bound;
                        hi_l_d = hi_bound;
                    end
                end
            end
            LOAD: begin
                pos_d    = lo_l_q;
                dir_up_d = 1'b1;
                state_d  = UP;
            end
            UP: begin
                if (adv) begin
                    pos_d = pos_inc;
                    if (pos_inc == hi_l_q) begin
                        if (DWELL > 0) begin
                            state_d = DWELL_HI;
                            dwell_d = DWELL_INIT;
                        end else begin
                            state_d  = DOWN;
                            dir_up_d = 1'b0;
                        end
                    end
                end
            end
            DWELL_HI: begin
                if (adv) begin
                    dwell_d = dwell_dec;
                    if (dwell_dec == '0) begin
                        state_d  = DOWN;
                        dir_up_d = 1'b0;
                    end
                end
            end
            DOWN: begin
                if (adv) begin
                    pos_d = pos_dec;
                    if (pos_dec == lo_l_q) begin
                        if (DWELL > 0) begin
                            state_d = DWELL_LO;
                            dwell_d = DWELL_INIT;
                        end else begin
                            state_d  = UP;
                            dir_up_d = 1'b1;
                        end
                    end
                end
            end
            DWELL_LO: begin
                if (adv) begin
                    dwell_d = dwell_dec;
                    if (dwell_dec == '0) begin
                        state_d  = UP;
                        dir_up_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef LED_SCAN_TRAIL_EN
    logic [POS_W-1:0] trail_q, trail_d;

    // Trail only follows real position changes, so it stays put during dwell.
    always_comb begin
        trail_d = trail_q;
        if (pos_d != pos_q) begin
            trail_d = pos_q;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            trail_q <= '0;
        end else begin
            trail_q <= trail_d;
        end
    end

    assign led_d = onehot(pos_d) | onehot(trail_d);
`else
    assign led_d = onehot(pos_d);
`endif

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            presc_q  <= '0;
            pos_q    <= '0;
            lo_l_q   <= '0;
            hi_l_q   <= MAX_POS;
            dwell_q  <= '0;
            dir_up_q <= 1'b1;
            led_q    <= NUM_LEDS'(1);
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            pos_q    <= pos_d;
            lo_l_q   <= lo_l_d;
            hi_l_q   <= hi_l_d;
            dwell_q  <= dwell_d;
            dir_up_q <= dir_up_d;
            led_q    <= led_d;
        end
    end

    assign LEDR   = led_q;
    assign pos    = pos_q;
    assign dir_up = dir_up_q;
    assign at_end = (state_q == DWELL_HI) || (state_q == DWELL_LO);
    assign busy   = (state_q != IDLE);

endmodule
